// File: rtl/svc_soc_run_ctrl_pkg.sv
// Shared types and constants for the SoC run controller (state encoding, timeout reason code).
package svc_soc_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int unsigned REASON_TIMEOUT = 0;

endpackage

// File: rtl/svc_soc_run_ctrl_if.sv
// Signal bundle for the run controller: run-control inputs from the SoC and status outputs.
interface svc_soc_run_ctrl_if
  import svc_soc_run_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 32
);
  localparam int unsigned REASON_W = $clog2(NUM_SRC + 1);

  logic                start;
  logic [NUM_SRC-1:0]  stop_req;
  logic                retire;
  logic                wdog_kick;
  logic                drain_busy;
  logic                running;
  logic                done;
  logic                timeout;
  logic [REASON_W-1:0] reason;
  logic [CNT_W-1:0]    cycles;
  logic [CNT_W-1:0]    instrs;

  modport master (
    output start, stop_req, retire, wdog_kick, drain_busy,
    input  running, done, timeout, reason, cycles, instrs
  );

  modport slave (
    input  start, stop_req, retire, wdog_kick, drain_busy,
    output running, done, timeout, reason, cycles, instrs
  );

endinterface

// File: rtl/svc_soc_run_wdog.sv
// RUN-phase watchdog: count cleared while disabled or kicked; expired is asserted on the limit edge.
module svc_soc_run_wdog #(
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned WATCHDOG_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic kick,
  output logic expired
);

  generate
    if (WATCHDOG_CYCLES == 0) begin : g_off
      logic w_unused;
      assign w_unused = ^{clk, rst_n, en, kick};
      assign expired  = 1'b0;
    end else begin : g_on
      localparam logic [CNT_W-1:0] LAST = CNT_W'(WATCHDOG_CYCLES - 1);
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (!en || kick) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign expired = en && !kick && (r_cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/svc_soc_run_ctrl.sv
// SoC run controller: IDLE -> RUN -> DRAIN -> DONE with watchdog and stop-source arbitration.
// Optional retired-instruction counter enabled by macro SVC_SOC_RUN_CTRL_INSTRS_EN.
module svc_soc_run_ctrl
  import svc_soc_run_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_SRC          = 2,
  parameter  int unsigned CNT_W            = 32,
  parameter  int unsigned WATCHDOG_CYCLES  = 100000,
  parameter  int unsigned DRAIN_CYCLES     = 16,
  parameter  int unsigned DRAIN_MAX_CYCLES = 4096,
  localparam int unsigned REASON_W         = $clog2(NUM_SRC + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NUM_SRC-1:0]  stop_req,
  input  logic                retire,
  input  logic                wdog_kick,
  input  logic                drain_busy,
  output logic                running,
  output logic                done,
  output logic                timeout,
  output logic [REASON_W-1:0] reason,
  output logic [CNT_W-1:0]    cycles,
  output logic [CNT_W-1:0]    instrs
);

  localparam int unsigned DRAIN_W        = $clog2(DRAIN_MAX_CYCLES + 1);
  localparam int unsigned DRAIN_MIN_LAST = (DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1;
  localparam int unsigned DRAIN_MAX_LAST = (DRAIN_MAX_CYCLES == 0) ? 0 : DRAIN_MAX_CYCLES - 1;

  generate
    if ((64'(WATCHDOG_CYCLES) >> CNT_W) != 64'd0) begin : g_bad_wdog
      $error("WATCHDOG_CYCLES does not fit in CNT_W bits");
    end
  endgenerate

  state_t              r_state, w_state_nx;
  logic                w_run, w_expired, w_stop_any, w_drain_exit;
  logic [REASON_W-1:0] w_src;
  logic [DRAIN_W-1:0]  r_drain_cnt;
  logic                r_running, r_done, r_timeout;
  logic [REASON_W-1:0] r_reason;
  logic [CNT_W-1:0]    r_cycles;

  assign w_run = (r_state == ST_RUN);

  svc_soc_run_wdog #(
    .CNT_W           (CNT_W),
    .WATCHDOG_CYCLES (WATCHDOG_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (w_run),
    .kick    (wdog_kick),
    .expired (w_expired)
  );

  // Descending scan so the lowest set index is the one left in w_src.
  always_comb begin
    w_src = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (stop_req[i-1]) w_src = REASON_W'(i);
    end
    w_stop_any   = |stop_req;
    w_drain_exit = ((32'(r_drain_cnt) >= DRAIN_MIN_LAST) && !drain_busy) ||
                   (32'(r_drain_cnt) == DRAIN_MAX_LAST);
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE:  if (start) w_state_nx = ST_RUN;
      ST_RUN:   if (w_stop_any || w_expired) w_state_nx = ST_DRAIN;
      ST_DRAIN: if (w_drain_exit) w_state_nx = ST_DONE;
      ST_DONE:  w_state_nx = ST_DONE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_reason    <= '0;
      r_cycles    <= '0;
      r_drain_cnt <= '0;
    end else begin
      r_running <= (w_state_nx == ST_RUN);
      r_done    <= (w_state_nx == ST_DONE);
      if (r_state == ST_DRAIN) r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
      else                     r_drain_cnt <= '0;
      if (r_state == ST_IDLE && start) begin
        r_cycles <= '0;
      end else if (w_run) begin
        if (r_cycles != '1) r_cycles <= r_cycles + CNT_W'(1);
        // A source sampled together with expiry takes precedence over the timeout.
        if (w_state_nx == ST_DRAIN) begin
          r_reason  <= w_stop_any ? w_src : REASON_W'(REASON_TIMEOUT);
          r_timeout <= !w_stop_any;
        end
      end
    end
  end

  assign running = r_running;
  assign done    = r_done;
  assign timeout = r_timeout;
  assign reason  = r_reason;
  assign cycles  = r_cycles;

`ifdef SVC_SOC_RUN_CTRL_INSTRS_EN
  logic [CNT_W-1:0] r_instrs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instrs <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_instrs <= '0;
    end else if (w_run && retire && (r_instrs != '1)) begin
      r_instrs <= r_instrs + CNT_W'(1);
    end
  end

  assign instrs = r_instrs;
`else
  logic w_unused_retire;
  assign w_unused_retire = retire;
  assign instrs          = '0;
`endif

endmodule

// File: tb/tb_svc_soc_run_ctrl.sv
// Self-checking bench for svc_soc_run_ctrl: directed scenarios plus randomized runs against an edge-level model.
`timescale 1ns/1ps
module tb_svc_soc_run_ctrl;
  import svc_soc_run_ctrl_pkg::*;

  localparam int unsigned NSRC = 2;
  localparam int unsigned CW   = 32;
  localparam int          WD   = 100;
  localparam int          DC   = 16;
  localparam int          DM   = 64;
  localparam int          MAXE = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  svc_soc_run_ctrl_if #(.NUM_SRC(NSRC), .CNT_W(CW)) bus ();

  svc_soc_run_ctrl #(
    .NUM_SRC(NSRC), .CNT_W(CW), .WATCHDOG_CYCLES(WD),
    .DRAIN_CYCLES(DC), .DRAIN_MAX_CYCLES(DM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(bus.start), .stop_req(bus.stop_req),
    .retire(bus.retire), .wdog_kick(bus.wdog_kick), .drain_busy(bus.drain_busy),
    .running(bus.running), .done(bus.done), .timeout(bus.timeout),
    .reason(bus.reason), .cycles(bus.cycles), .instrs(bus.instrs)
  );

  // Small instance: 8-bit counters, watchdog disabled, short drain.
  logic       s_rst_n = 1'b0, s_start = 1'b0, s_retire = 1'b0, s_kick = 1'b0, s_busy = 1'b0;
  logic [1:0] s_stop = '0;
  logic       s_running, s_done, s_timeout;
  logic [1:0] s_reason;
  logic [7:0] s_cycles, s_instrs;

  svc_soc_run_ctrl #(
    .NUM_SRC(2), .CNT_W(8), .WATCHDOG_CYCLES(0), .DRAIN_CYCLES(2), .DRAIN_MAX_CYCLES(4)
  ) dut_small (
    .clk(clk), .rst_n(s_rst_n), .start(s_start), .stop_req(s_stop), .retire(s_retire),
    .wdog_kick(s_kick), .drain_busy(s_busy), .running(s_running), .done(s_done),
    .timeout(s_timeout), .reason(s_reason), .cycles(s_cycles), .instrs(s_instrs)
  );

  // Stimulus per RUN edge (index 1 = first edge after the start edge).
  bit         kick_v [MAXE+1];
  bit         ret_v  [MAXE+1];
  logic [1:0] stop_v [MAXE+1];
  int         busy_len;

  int e_end, e_reason, e_timeout, e_instrs, e_drain;
  int o_end, o_drain;
  logic o_idle_ok, o_hold_ok, o_timeout;
  logic [1:0]  o_reason;
  logic [31:0] o_cycles, o_instrs;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.start = 1'b0; bus.stop_req = '0; bus.retire = 1'b0;
    bus.wdog_kick = 1'b0; bus.drain_busy = 1'b0;
  endtask

  task automatic clear_stim;
    for (int k = 0; k <= MAXE; k++) begin
      kick_v[k] = 1'b0; ret_v[k] = 1'b0; stop_v[k] = '0;
    end
    busy_len = 0;
  endtask

  // Reference: scan edges for the first stop or unkicked watchdog limit.
  task automatic model;
    int last;
    last = 0; e_end = -1; e_reason = 0; e_timeout = 0; e_instrs = 0;
    for (int k = 1; k <= MAXE; k++) begin
      if (stop_v[k] != 2'b00) begin
        e_end = k; e_reason = stop_v[k][0] ? 1 : 2; e_timeout = 0; break;
      end
      if (!kick_v[k] && (k - last) == WD) begin
        e_end = k; e_reason = 0; e_timeout = 1; break;
      end
      if (kick_v[k]) last = k;
    end
`ifdef SVC_SOC_RUN_CTRL_INSTRS_EN
    for (int k = 1; k <= e_end; k++) if (ret_v[k]) e_instrs++;
`endif
    e_drain = (busy_len + 1 > DC) ? busy_len + 1 : DC;
    if (e_drain > DM) e_drain = DM;
  endtask

  task automatic drive;
    clear_inputs();
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
    bus.stop_req = '1; bus.retire = 1'b1; bus.wdog_kick = 1'b1;
    tick(); tick();
    o_idle_ok = !bus.running && !bus.done && bus.cycles == 0 && bus.instrs == 0;
    clear_inputs();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    o_end = -1;
    for (int k = 1; k <= MAXE; k++) begin
      bus.stop_req = stop_v[k]; bus.retire = ret_v[k]; bus.wdog_kick = kick_v[k];
      tick();
      if (!bus.running) begin o_end = k; break; end
    end
    clear_inputs();
    o_reason = bus.reason; o_timeout = bus.timeout; o_cycles = bus.cycles; o_instrs = bus.instrs;
    o_drain = -1;
    for (int j = 1; j <= 200; j++) begin
      bus.drain_busy = (j <= busy_len);
      tick();
      if (bus.done) begin o_drain = j; break; end
    end
    bus.drain_busy = 1'b0;
    bus.start = 1'b1; bus.stop_req = '1; bus.retire = 1'b1;
    tick(); tick();
    o_hold_ok = bus.done && !bus.running && bus.cycles == o_cycles &&
                bus.reason == o_reason && bus.instrs == o_instrs;
    clear_inputs();
  endtask

  task automatic test_reset;
    bus.start = 1'b1; bus.stop_req = '1; bus.retire = 1'b1; bus.wdog_kick = 1'b1;
    rst_n = 1'b0; tick(); tick();
    checks++;
    if (bus.running !== 1'b0 || bus.done !== 1'b0 || bus.timeout !== 1'b0 ||
        bus.reason !== 2'd0 || bus.cycles !== 32'd0 || bus.instrs !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: running=%b done=%b timeout=%b reason=%0d cycles=%0d instrs=%0d, expected all 0",
               bus.running, bus.done, bus.timeout, bus.reason, bus.cycles, bus.instrs);
    end
    clear_inputs(); rst_n = 1'b1; tick();
    checks++;
    if (bus.running !== 1'b0) begin
      failures++; $display("FAIL idle_hold: running=%b expected 0", bus.running);
    end
  endtask

  task automatic test_timeout;
    clear_stim(); model(); drive();
    checks++;
    if (o_end != 100 || o_cycles !== 32'd100 || o_reason !== 2'd0 || o_timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout: end=%0d cycles=%0d reason=%0d timeout=%b expected 100/100/0/1",
               o_end, o_cycles, o_reason, o_timeout);
    end
  endtask

  task automatic test_kick;
    clear_stim(); kick_v[60] = 1'b1; model(); drive();
    checks++;
    if (o_end != 160 || o_cycles !== 32'd160 || o_timeout !== 1'b1 || e_end != 160) begin
      failures++;
      $display("FAIL kick: end=%0d cycles=%0d timeout=%b expected 160/160/1", o_end, o_cycles, o_timeout);
    end
  endtask

  task automatic test_priority;
    clear_stim(); stop_v[50] = 2'b11; drive();
    checks++;
    if (o_end != 50 || o_cycles !== 32'd50 || o_reason !== 2'd1 || o_timeout !== 1'b0) begin
      failures++;
      $display("FAIL priority: end=%0d cycles=%0d reason=%0d timeout=%b expected 50/50/1/0",
               o_end, o_cycles, o_reason, o_timeout);
    end
  endtask

  task automatic test_stop_vs_expiry;
    clear_stim(); stop_v[100] = 2'b10; drive();
    checks++;
    if (o_end != 100 || o_cycles !== 32'd100 || o_reason !== 2'd2 || o_timeout !== 1'b0) begin
      failures++;
      $display("FAIL stop_vs_expiry: end=%0d cycles=%0d reason=%0d timeout=%b expected 100/100/2/0",
               o_end, o_cycles, o_reason, o_timeout);
    end
  endtask

  task automatic test_drain;
    clear_stim(); stop_v[10] = 2'b01; busy_len = 40; drive();
    checks++;
    if (o_drain != 41) begin
      failures++; $display("FAIL drain_busy40: drain_edges=%0d expected 41", o_drain);
    end
    clear_stim(); stop_v[10] = 2'b01; busy_len = 1000; drive();
    checks++;
    if (o_drain != 64) begin
      failures++; $display("FAIL drain_stuck: drain_edges=%0d expected 64", o_drain);
    end
    clear_stim(); stop_v[10] = 2'b01; busy_len = 0; drive();
    checks++;
    if (o_drain != 16) begin
      failures++; $display("FAIL drain_min: drain_edges=%0d expected 16", o_drain);
    end
  endtask

  task automatic test_reset_mid_drain;
    clear_inputs();
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int k = 1; k < 20; k++) tick();
    bus.stop_req = 2'b01; tick(); bus.stop_req = '0;
    bus.drain_busy = 1'b1;
    for (int j = 1; j <= 5; j++) tick();
    rst_n = 1'b0; #1;
    checks++;
    if (bus.running !== 1'b0 || bus.done !== 1'b0 || bus.timeout !== 1'b0 ||
        bus.reason !== 2'd0 || bus.cycles !== 32'd0 || bus.instrs !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_drain: running=%b done=%b reason=%0d cycles=%0d expected all 0",
               bus.running, bus.done, bus.reason, bus.cycles);
    end
    tick(); rst_n = 1'b1; bus.drain_busy = 1'b0; tick();
    checks++;
    if (bus.done !== 1'b0 || bus.running !== 1'b0) begin
      failures++; $display("FAIL no_partial_done: done=%b running=%b expected 0/0", bus.done, bus.running);
    end
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    checks++;
    if (bus.running !== 1'b1 || bus.cycles !== 32'd0) begin
      failures++; $display("FAIL restart: running=%b cycles=%0d expected 1/0", bus.running, bus.cycles);
    end
    tick(); tick();
    checks++;
    if (bus.cycles !== 32'd2) begin
      failures++; $display("FAIL restart_count: cycles=%0d expected 2", bus.cycles);
    end
  endtask

  task automatic test_instrs;
    int exp_i;
    clear_stim();
    for (int k = 1; k <= 30; k++) ret_v[k] = 1'b1;
    stop_v[40] = 2'b01;
    drive();
`ifdef SVC_SOC_RUN_CTRL_INSTRS_EN
    exp_i = 30;
`else
    exp_i = 0;
`endif
    checks++;
    if (o_instrs !== 32'(exp_i)) begin
      failures++; $display("FAIL instrs30: instrs=%0d expected %0d", o_instrs, exp_i);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 12; it++) begin
      clear_stim();
      for (int k = 1; k < 250; k++) begin
        kick_v[k] = ($urandom_range(0, 49) == 0);
        ret_v[k]  = $urandom_range(0, 1) == 1;
      end
      if ($urandom_range(0, 2) != 0) stop_v[$urandom_range(1, 220)] = 2'($urandom_range(1, 3));
      busy_len = $urandom_range(0, 80);
      model(); drive();
      checks++;
      if (o_end != e_end || o_cycles !== 32'(e_end)) begin
        failures++;
        $display("FAIL rand_end[%0d]: end=%0d cycles=%0d expected %0d", it, o_end, o_cycles, e_end);
      end
      checks++;
      if (o_reason !== 2'(e_reason) || o_timeout !== 1'(e_timeout)) begin
        failures++;
        $display("FAIL rand_reason[%0d]: reason=%0d timeout=%b expected %0d/%0d",
                 it, o_reason, o_timeout, e_reason, e_timeout);
      end
      checks++;
      if (o_instrs !== 32'(e_instrs)) begin
        failures++; $display("FAIL rand_instrs[%0d]: instrs=%0d expected %0d", it, o_instrs, e_instrs);
      end
      checks++;
      if (o_drain != e_drain) begin
        failures++; $display("FAIL rand_drain[%0d]: drain_edges=%0d expected %0d", it, o_drain, e_drain);
      end
      checks++;
      if (o_idle_ok !== 1'b1 || o_hold_ok !== 1'b1) begin
        failures++; $display("FAIL rand_idle_done[%0d]: idle_ok=%b hold_ok=%b expected 1/1", it, o_idle_ok, o_hold_ok);
      end
    end
  endtask

  task automatic test_saturation;
    int exp_i;
    s_rst_n = 1'b0; tick(); s_rst_n = 1'b1; tick();
    s_start = 1'b1; tick(); s_start = 1'b0;
    s_retire = 1'b1;
    for (int k = 1; k <= 300; k++) tick();
    checks++;
    if (s_running !== 1'b1 || s_cycles !== 8'hFF) begin
      failures++; $display("FAIL sat_cycles: running=%b cycles=%0d expected 1/255", s_running, s_cycles);
    end
    s_stop = 2'b10; tick(); s_stop = '0; s_retire = 1'b0;
`ifdef SVC_SOC_RUN_CTRL_INSTRS_EN
    exp_i = 255;
`else
    exp_i = 0;
`endif
    checks++;
    if (s_running !== 1'b0 || s_reason !== 2'd2 || s_timeout !== 1'b0 ||
        s_cycles !== 8'hFF || s_instrs !== 8'(exp_i)) begin
      failures++;
      $display("FAIL sat_stop: running=%b reason=%0d timeout=%b cycles=%0d instrs=%0d expected 0/2/0/255/%0d",
               s_running, s_reason, s_timeout, s_cycles, s_instrs, exp_i);
    end
    tick(); tick();
    checks++;
    if (s_done !== 1'b1) begin
      failures++; $display("FAIL sat_drain: done=%b expected 1", s_done);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_timeout();
    test_kick();
    test_priority();
    test_stop_vs_expiry();
    test_drain();
    test_reset_mid_drain();
    test_instrs();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
